fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/y86_pkg.sv | 39 +++
 rtl/instr_align.sv | 43 ++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the aligned-instruction payload used by the fetch stage.
package y86_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned INSTR_W = 80;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned STAT_W  = 3;

    localparam logic [NIB_W-1:0] IHALT   = 4'h0;
    localparam logic [NIB_W-1:0] INOP    = 4'h1;
    localparam logic [NIB_W-1:0] IRRMOVQ = 4'h2;
    localparam logic [NIB_W-1:0] IIRMOVQ = 4'h3;
    localparam logic [NIB_W-1:0] IRMMOVQ = 4'h4;
    localparam logic [NIB_W-1:0] IMRMOVQ = 4'h5;
    localparam logic [NIB_W-1:0] IOPQ    = 4'h6;
    localparam logic [NIB_W-1:0] IJXX    = 4'h7;
    localparam logic [NIB_W-1:0] ICALL   = 4'h8;
    localparam logic [NIB_W-1:0] IRET    = 4'h9;
    localparam logic [NIB_W-1:0] IPUSHQ  = 4'hA;
    localparam logic [NIB_W-1:0] IPOPQ   = 4'hB;

    localparam logic [STAT_W-1:0] SAOK = 3'd1;
    localparam logic [STAT_W-1:0] SHLT = 3'd2;
    localparam logic [STAT_W-1:0] SADR = 3'd3;
    localparam logic [STAT_W-1:0] SINS = 3'd4;

    localparam logic [NIB_W-1:0] RNONE = 4'hF;

    typedef struct packed {
        logic [NIB_W-1:0] icode;
        logic [NIB_W-1:0] ifun;
        logic [NIB_W-1:0] ra;
        logic [NIB_W-1:0] rb;
        logic [XLEN-1:0]  valc;
        logic             need_regids;
        logic             need_valc;
    } align_t;

endpackage

// File: rtl/instr_align.sv
// Splits the raw instruction bytes into fields and aligns valC (combinational).
module instr_align
    import y86_pkg::*;
(
    input  logic [INSTR_W-1:0] imem_data,
    output align_t             fields
);

    logic [NIB_W-1:0] icode;
    logic             need_regids;
    logic             need_valc;

    assign icode = imem_data[7:4];

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (icode)
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            IJXX, ICALL: need_valc = 1'b1;
            default: ;
        endcase
    end

    // valC starts one byte later when a register-specifier byte is present
    always_comb begin
        fields             = '0;
        fields.icode       = icode;
        fields.ifun        = imem_data[3:0];
        fields.ra          = need_regids ? imem_data[15:12] : RNONE;
        fields.rb          = need_regids ? imem_data[11:8]  : RNONE;
        fields.need_regids = need_regids;
        fields.need_valc   = need_valc;
        if (need_valc) begin
            fields.valc = need_regids ? imem_data[79:16] : imem_data[71:8];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 pipeline fetch stage: PC select, decode of instruction bytes, next-PC prediction.
// Optional FETCH_PERF_CNT_EN adds a fetched-instruction counter on fetch_count.
module fetch_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 F_stall,
    input  logic [NIB_W-1:0]     M_icode,
    input  logic                 M_Cnd,
    input  logic [XLEN-1:0]      M_valA,
    input  logic [NIB_W-1:0]     W_icode,
    input  logic [XLEN-1:0]      W_valM,
    output logic [XLEN-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    input  logic                 imem_error,
    output logic [NIB_W-1:0]     f_icode,
    output logic [NIB_W-1:0]     f_ifun,
    output logic [NIB_W-1:0]     f_rA,
    output logic [NIB_W-1:0]     f_rB,
    output logic [XLEN-1:0]      f_valC,
    output logic [XLEN-1:0]      f_valP,
    output logic [STAT_W-1:0]    f_stat,
    output logic [XLEN-1:0]      F_predPC,
    output logic [XLEN-1:0]      fetch_count
);

    align_t            fa;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   valp;
    logic [XLEN-1:0]   pred_pc;
    logic [STAT_W-1:0] stat;
    logic              bubble;

    // Mispredicted branch outranks a returning ret
    always_comb begin
        pc = F_predPC;
        if (M_icode == IJXX && !M_Cnd) begin
            pc = M_valA;
        end else if (W_icode == IRET) begin
            pc = W_valM;
        end
    end

    instr_align u_align (
        .imem_data (imem_data),
        .fields    (fa)
    );

    always_comb begin
        stat = SAOK;
        if (imem_error) begin
            stat = SADR;
        end else if (fa.icode > IPOPQ) begin
            stat = SINS;
        end else if (fa.icode == IHALT) begin
            stat = SHLT;
        end
    end

    assign bubble  = (stat == SADR) || (stat == SINS);
    assign valp    = pc + XLEN'(1) + XLEN'(fa.need_regids) + (fa.need_valc ? XLEN'(8) : XLEN'(0));
    assign pred_pc = (fa.icode == IJXX || fa.icode == ICALL) ? fa.valc : valp;

    assign imem_addr = pc;
    assign f_icode   = bubble ? INOP : fa.icode;
    assign f_ifun    = bubble ? 4'h0 : fa.ifun;
    assign f_rA      = bubble ? RNONE : fa.ra;
    assign f_rB      = bubble ? RNONE : fa.rb;
    assign f_valC    = fa.valc;
    assign f_valP    = valp;
    assign f_stat    = stat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_predPC <= RESET_PC;
        end else if (!F_stall) begin
            F_predPC <= pred_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!F_stall && stat == SAOK) begin
            count_q <= count_q + XLEN'(1);
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against an instruction-length based reference model.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [2:0]  f_stat;
    logic [63:0] F_predPC;
    logic [63:0] fetch_count;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] pred;
        logic [2:0]  stat;
    } exp_t;

    int          errors;
    int          checks;
    logic [63:0] exp_pred;
    logic [63:0] exp_cnt;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .F_stall     (F_stall),
        .M_icode     (M_icode),
        .M_Cnd       (M_Cnd),
        .M_valA      (M_valA),
        .W_icode     (W_icode),
        .W_valM      (W_valM),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_error  (imem_error),
        .f_icode     (f_icode),
        .f_ifun      (f_ifun),
        .f_rA        (f_rA),
        .f_rB        (f_rB),
        .f_valC      (f_valC),
        .f_valP      (f_valP),
        .f_stat      (f_stat),
        .F_predPC    (F_predPC),
        .fetch_count (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: every icode has a fixed instruction length; fields follow from it
    function automatic exp_t ref_fetch(input logic [79:0] data, input logic err, input logic [63:0] pc);
        exp_t       e;
        logic [7:0] b [10];
        int         len;
        for (int i = 0; i < 10; i++) b[i] = data[8*i +: 8];
        e = '0;
        e.icode = b[0][7:4];
        e.ifun  = b[0][3:0];
        case (e.icode)
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h3, 4'h4, 4'h5:       len = 10;
            4'h7, 4'h8:             len = 9;
            default:                len = 1;
        endcase
        e.ra = 4'hF;
        e.rb = 4'hF;
        if (len == 2 || len == 10) begin
            e.ra = b[1][7:4];
            e.rb = b[1][3:0];
        end
        if (len >= 9) for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = b[len - 8 + k];
        e.valp = pc + 64'(len);
        e.pred = (e.icode == 4'h7 || e.icode == 4'h8) ? e.valc : e.valp;
        if (err)                 e.stat = 3'd3;
        else if (e.icode > 4'hB) e.stat = 3'd4;
        else if (e.icode == 0)   e.stat = 3'd2;
        else                     e.stat = 3'd1;
        if (e.stat == 3'd3 || e.stat == 3'd4) begin
            e.icode = 4'h1;
            e.ifun  = 4'h0;
            e.ra    = 4'hF;
            e.rb    = 4'hF;
        end
        return e;
    endfunction

    function automatic logic [63:0] ref_pc(input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                                           input logic [3:0] wi, input logic [63:0] wm, input logic [63:0] pred);
        if (mi == 4'h7 && !mc) return ma;
        if (wi == 4'h9) return wm;
        return pred;
    endfunction

    // Clock edge plus the model's view of what the registers should capture
    task automatic advance(input logic [63:0] nxt, input logic aok);
        @(posedge clk);
        if (rst_n && !F_stall) begin
            exp_pred = nxt;
`ifdef FETCH_PERF_CNT_EN
            if (aok) exp_cnt = exp_cnt + 64'd1;
`endif
        end
        #1;
    endtask

    task automatic idle_inputs();
        F_stall    = 1'b0;
        M_icode    = 4'h1;
        M_Cnd      = 1'b1;
        M_valA     = 64'h0;
        W_icode    = 4'h1;
        W_valM     = 64'h0;
        imem_error = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        idle_inputs();
        rst_n     = 1'b0;
        imem_data = {64'h10, 8'hF2, 8'h30};
        repeat (2) @(posedge clk);
        #1;
        exp_pred = 64'h0;
        exp_cnt  = 64'h0;
        e = ref_fetch(imem_data, 1'b0, 64'h0);
        checks++; if (F_predPC !== 64'h0) begin errors++; $display("FAIL reset_predpc got %h exp %h", F_predPC, 64'h0); end
        checks++; if (fetch_count !== 64'h0) begin errors++; $display("FAIL reset_count got %h exp 0", fetch_count); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (f_icode !== e.icode) begin errors++; $display("FAIL reset_decode got %h exp %h", f_icode, e.icode); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_irmovq();
        exp_t e;
        idle_inputs();
        imem_data = {64'h10, 8'hF2, 8'h30};
        #1;
        e = ref_fetch(imem_data, 1'b0, exp_pred);
        checks++; if (f_icode !== 4'h3) begin errors++; $display("FAIL irmovq_icode got %h exp 3", f_icode); end
        checks++; if (f_rA !== 4'hF || f_rB !== 4'h2) begin errors++; $display("FAIL irmovq_regs got %h/%h exp F/2", f_rA, f_rB); end
        checks++; if (f_valC !== 64'd16) begin errors++; $display("FAIL irmovq_valc got %h exp 10", f_valC); end
        checks++; if (f_valP !== 64'd10) begin errors++; $display("FAIL irmovq_valp got %h exp a", f_valP); end
        advance(e.pred, e.stat == 3'd1);
        checks++; if (F_predPC !== 64'd10) begin errors++; $display("FAIL irmovq_pred got %h exp a", F_predPC); end
        checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL irmovq_count got %h exp %h", fetch_count, exp_cnt); end
    endtask

    task automatic test_jump_mispredict();
        exp_t e;
        idle_inputs();
        W_icode   = 4'h9;
        W_valM    = 64'h20;
        imem_data = {8'h00, 64'h100, 8'h70};
        #1;
        e = ref_fetch(imem_data, 1'b0, 64'h20);
        checks++; if (imem_addr !== 64'h20) begin errors++; $display("FAIL jxx_ret_addr got %h exp 20", imem_addr); end
        checks++; if (f_valC !== 64'h100 || f_valP !== 64'h29) begin errors++; $display("FAIL jxx_vals got %h/%h exp 100/29", f_valC, f_valP); end
        advance(e.pred, e.stat == 3'd1);
        checks++; if (F_predPC !== 64'h100) begin errors++; $display("FAIL jxx_pred got %h exp 100", F_predPC); end
        W_icode = 4'h1;
        M_icode = 4'h7;
        M_Cnd   = 1'b0;
        M_valA  = 64'h29;
        #1;
        checks++; if (imem_addr !== 64'h29) begin errors++; $display("FAIL jxx_mispredict_addr got %h exp 29", imem_addr); end
        M_Cnd = 1'b1;
        #1;
        checks++; if (imem_addr !== 64'h100) begin errors++; $display("FAIL jxx_taken_addr got %h exp 100", imem_addr); end
    endtask

    task automatic test_priority();
        idle_inputs();
        F_stall = 1'b1;
        M_icode = 4'h7;
        M_Cnd   = 1'b0;
        M_valA  = 64'h1234;
        W_icode = 4'h9;
        W_valM  = 64'h5678;
        #1;
        checks++; if (imem_addr !== 64'h1234) begin errors++; $display("FAIL prio_m_wins got %h exp 1234", imem_addr); end
        M_Cnd = 1'b1;
        #1;
        checks++; if (imem_addr !== 64'h5678) begin errors++; $display("FAIL prio_w_ret got %h exp 5678", imem_addr); end
    endtask

    task automatic test_status();
        exp_t e;
        idle_inputs();
        F_stall   = 1'b1;
        imem_data = {64'hFFFF_0000_1234_5678, 8'h45, 8'hC0};
        #1;
        checks++; if (f_stat !== 3'd4 || f_icode !== 4'h1) begin errors++; $display("FAIL stat_ins got %0d/%h exp 4/1", f_stat, f_icode); end
        checks++; if (f_ifun !== 4'h0 || f_rA !== 4'hF || f_rB !== 4'hF) begin errors++; $display("FAIL stat_ins_bubble got %h %h %h", f_ifun, f_rA, f_rB); end
        imem_data  = {64'h10, 8'h12, 8'h30};
        imem_error = 1'b1;
        #1;
        checks++; if (f_stat !== 3'd3 || f_icode !== 4'h1 || f_rB !== 4'hF) begin errors++; $display("FAIL stat_adr got %0d/%h/%h exp 3/1/F", f_stat, f_icode, f_rB); end
        imem_error = 1'b0;
        imem_data  = 80'h0;
        F_stall    = 1'b0;
        #1;
        e = ref_fetch(imem_data, 1'b0, exp_pred);
        checks++; if (f_stat !== 3'd2 || f_icode !== 4'h0) begin errors++; $display("FAIL stat_hlt got %0d/%h exp 2/0", f_stat, f_icode); end
        advance(e.pred, e.stat == 3'd1);
        checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL hlt_count got %h exp %h", fetch_count, exp_cnt); end
        checks++; if (F_predPC !== exp_pred) begin errors++; $display("FAIL hlt_pred got %h exp %h", F_predPC, exp_pred); end
    endtask

    task automatic test_stall();
        logic [63:0] held_pc;
        logic [63:0] held_cnt;
        idle_inputs();
        imem_data = {8'h00, 64'h4000, 8'h80};
        F_stall   = 1'b1;
        held_pc   = exp_pred;
        held_cnt  = exp_cnt;
        for (int c = 0; c < 3; c++) begin
            advance(64'h4000, 1'b1);
            checks++; if (F_predPC !== held_pc) begin errors++; $display("FAIL stall_pred c%0d got %h exp %h", c, F_predPC, held_pc); end
            checks++; if (fetch_count !== held_cnt) begin errors++; $display("FAIL stall_count c%0d got %h exp %h", c, fetch_count, held_cnt); end
        end
        F_stall = 1'b0;
        advance(64'h4000, 1'b1);
        checks++; if (F_predPC !== 64'h4000) begin errors++; $display("FAIL stall_release got %h exp 4000", F_predPC); end
        checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL stall_release_count got %h exp %h", fetch_count, exp_cnt); end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [63:0] pc;
        int          mode;
        for (int n = 0; n < 300; n++) begin
            F_stall   = ($urandom_range(0, 3) == 0);
            imem_data = {16'($urandom), $urandom, $urandom};
            imem_data[7:4] = 4'($urandom_range(0, 11));
            imem_error = 1'b0;
            mode    = $urandom_range(0, 3);
            M_icode = (mode == 0 || mode == 2) ? 4'h7 : 4'($urandom_range(0, 6));
            M_Cnd   = (mode == 0 || mode == 2) ? 1'b0 : 1'($urandom);
            W_icode = (mode == 1 || mode == 2) ? 4'h9 : 4'($urandom_range(0, 8));
            M_valA  = {$urandom, $urandom};
            W_valM  = {$urandom, $urandom};
            #1;
            pc = ref_pc(M_icode, M_Cnd, M_valA, W_icode, W_valM, exp_pred);
            e  = ref_fetch(imem_data, 1'b0, pc);
            checks++; if (imem_addr !== pc) begin errors++; $display("FAIL rnd%0d addr got %h exp %h", n, imem_addr, pc); end
            checks++; if ({f_icode, f_ifun, f_rA, f_rB} !== {e.icode, e.ifun, e.ra, e.rb}) begin
                errors++; $display("FAIL rnd%0d fields got %h%h%h%h exp %h%h%h%h", n, f_icode, f_ifun, f_rA, f_rB, e.icode, e.ifun, e.ra, e.rb); end
            checks++; if (f_valC !== e.valc) begin errors++; $display("FAIL rnd%0d valc got %h exp %h", n, f_valC, e.valc); end
            checks++; if (f_valP !== e.valp) begin errors++; $display("FAIL rnd%0d valp got %h exp %h", n, f_valP, e.valp); end
            checks++; if (f_stat !== e.stat) begin errors++; $display("FAIL rnd%0d stat got %0d exp %0d", n, f_stat, e.stat); end
            advance(e.pred, e.stat == 3'd1);
            checks++; if (F_predPC !== exp_pred) begin errors++; $display("FAIL rnd%0d pred got %h exp %h", n, F_predPC, exp_pred); end
            checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL rnd%0d count got %h exp %h", n, fetch_count, exp_cnt); end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        idle_inputs();
        F_stall   = 1'b1;
        imem_data = {8'h00, 64'h777, 8'h80};
        #2;
        rst_n = 1'b0;
        #1;
        exp_pred = 64'h0;
        exp_cnt  = 64'h0;
        checks++; if (F_predPC !== 64'h0) begin errors++; $display("FAIL async_rst_pred got %h exp 0", F_predPC); end
        checks++; if (fetch_count !== 64'h0) begin errors++; $display("FAIL async_rst_count got %h exp 0", fetch_count); end
        checks++; if (f_icode !== 4'h8 || f_valC !== 64'h777) begin errors++; $display("FAIL async_rst_decode got %h/%h exp 8/777", f_icode, f_valC); end
        F_stall = 1'b0;
        advance(64'h777, 1'b1);
        checks++; if (F_predPC !== 64'h0) begin errors++; $display("FAIL rst_held_pred got %h exp 0", F_predPC); end
        #2;
        rst_n = 1'b1;
        imem_data = {72'h0, 8'h10};
        #1;
        e = ref_fetch(imem_data, 1'b0, 64'h0);
        advance(e.pred, e.stat == 3'd1);
        checks++; if (F_predPC !== 64'h1) begin errors++; $display("FAIL rst_resume_pred got %h exp 1", F_predPC); end
        checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL rst_resume_count got %h exp %h", fetch_count, exp_cnt); end
        W_icode = 4'h9;
        W_valM  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if (f_valP !== 64'h0) begin errors++; $display("FAIL wrap_valp got %h exp 0", f_valP); end
        advance(64'h0, 1'b1);
        checks++; if (F_predPC !== 64'h0) begin errors++; $display("FAIL wrap_pred got %h exp 0", F_predPC); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_irmovq();
        test_jump_mispredict();
        test_priority();
        test_status();
        test_stall();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
